// File: rtl/md5_block_padder.sv
// MD5 block padder: packs a byte stream into 512-bit little-endian blocks and
// appends the 0x80 marker, zero fill and 64-bit message bit length.
module md5_block_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);
    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_PAD  = 2'd1;
    localparam logic [1:0] S_LEN  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    localparam logic [1:0] K_DATA  = 2'd0;
    localparam logic [1:0] K_SPILL = 2'd1;
    localparam logic [1:0] K_FINAL = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_kind;
    logic [5:0]       r_ptr;
    logic [LEN_W-1:0] r_len;
    logic             r_first;
    logic             r_pad_pending;
    logic [511:0]     r_buf;
    logic [63:0]      w_len64;
    logic [8:0]       w_bit_ofs;

    // Length counter is zero-extended into the fixed 64-bit length field.
    always_comb begin
        w_len64 = '0;
        w_len64[LEN_W-1:0] = r_len;
    end

    assign w_bit_ofs = {r_ptr, 3'b000};

    assign in_ready  = (r_state == S_FILL) && !rst;
    assign blk_valid = (r_state == S_EMIT);
    assign blk_first = blk_valid && r_first;
    assign blk_last  = blk_valid && (r_kind == K_FINAL);
    assign blk_data  = r_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_kind        <= K_DATA;
            r_ptr         <= '0;
            r_len         <= '0;
            r_first       <= 1'b1;
            r_pad_pending <= 1'b0;
            r_buf         <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (in_valid) begin
                        if (!in_empty) begin
                            r_buf[w_bit_ofs +: 8] <= in_data;
                            r_ptr                 <= r_ptr + 6'd1;
                            r_len                 <= r_len + LEN_W'(8);
                        end
                        if (!in_empty && (r_ptr == 6'd63)) begin
                            r_state       <= S_EMIT;
                            r_kind        <= K_DATA;
                            r_pad_pending <= in_last;
                        end else if (in_last) begin
                            r_state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    // Bytes past ptr are still zero from the last block clear or reset.
                    r_buf[w_bit_ofs +: 8] <= 8'h80;
                    if (r_ptr <= 6'd55) begin
                        r_buf[511:448] <= w_len64;
                        r_kind         <= K_FINAL;
                    end else begin
                        r_kind <= K_SPILL;
                    end
                    r_state <= S_EMIT;
                end
                S_LEN: begin
                    r_buf[511:448] <= w_len64;
                    r_kind         <= K_FINAL;
                    r_state        <= S_EMIT;
                end
                default: begin
                    if (blk_ready) begin
                        r_buf   <= '0;
                        r_ptr   <= '0;
                        r_first <= 1'b0;
                        case (r_kind)
                            K_FINAL: begin
                                r_state       <= S_FILL;
                                r_len         <= '0;
                                r_first       <= 1'b1;
                                r_pad_pending <= 1'b0;
                            end
                            K_SPILL: r_state <= S_LEN;
                            default: begin
                                r_state       <= r_pad_pending ? S_PAD : S_FILL;
                                r_pad_pending <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md5_block_padder.sv
// Randomized bench for md5_block_padder against a message-level padding model.
module tb_md5_block_padder;
    typedef logic [7:0] u8;
    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    md5_block_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           acc_cyc = 0;
    int           first_rise = -1;
    int           rdy_mode = 1;
    exp_t         exp_q[$];
    logic [511:0] last_blk;
    logic         last_first;
    logic         last_last;
    logic         prev_v = 1'b0;
    logic         hold_v = 1'b0;
    logic [511:0] held_d;
    logic         held_f;
    logic         held_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Padded message = msg, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
    task automatic model_push(input u8 m[$]);
        u8 p[$];
        longint unsigned bits;
        int nb;
        exp_t e;
        p = m;
        bits = longint'(m.size()) * 8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(u8'(bits >> (8 * i)));
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.d = '0;
            for (int k = 0; k < 64; k++) e.d[8*k +: 8] = p[64*b + k];
            e.f = (b == 0);
            e.l = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       blk_ready = 1'b0;
                1:       blk_ready = 1'b1;
                default: blk_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (blk_valid) chk("mutex_in_ready", 512'(in_ready), 512'(0));
            if (blk_valid && hold_v) begin
                chk("stable_data", blk_data, held_d);
                chk("stable_first", 512'(blk_first), 512'(held_f));
                chk("stable_last", 512'(blk_last), 512'(held_l));
            end
            if (blk_valid && !prev_v && blk_first) first_rise = cyc;
            hold_v = blk_valid && !blk_ready;
            held_d = blk_data;
            held_f = blk_first;
            held_l = blk_last;
            if (blk_valid && blk_ready) begin
                last_blk   = blk_data;
                last_first = blk_first;
                last_last  = blk_last;
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", 512'(1), 512'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e.d);
                    chk("blk_first", 512'(blk_first), 512'(e.f));
                    chk("blk_last", 512'(blk_last), 512'(e.l));
                end
            end
            prev_v = blk_valid;
        end
    end

    task automatic send_beat(input u8 d, input bit last, input bit empty, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 3000) begin
                $display("FAIL in_ready_timeout: got 0 expected 1");
                n_fail++;
                $fatal(1, "stalled input");
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input u8 m[$], input bit sep_empty, input bit gaps);
        model_push(m);
        if (m.size() == 0) begin
            send_beat(8'h00, 1'b1, 1'b1, gaps);
        end else begin
            for (int i = 0; i < m.size(); i++)
                send_beat(m[i], (i == m.size() - 1) && !sep_empty, 1'b0, gaps);
            if (sep_empty) send_beat(8'h00, 1'b1, 1'b1, gaps);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || blk_valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("drain_timeout", 512'(1), 512'(0));
    endtask

    task automatic fill_msg(output u8 m[$], input int n, input u8 v);
        m = {};
        for (int i = 0; i < n; i++) m.push_back(v);
    endtask

    task automatic run_abc();
        u8 m[$];
        logic [511:0] lit;
        m = {8'h61, 8'h62, 8'h63};
        first_rise = -1;
        send_msg(m, 1'b0, 1'b0);
        wait_drain();
        lit = '0;
        lit[31:0]    = 32'h80636261;
        lit[455:448] = 8'h18;
        chk("abc_literal", last_blk, lit);
        chk("abc_first_last", 512'({last_first, last_last}), 512'(2'b11));
        chk("abc_latency", 512'(first_rise - acc_cyc), 512'(2));
    endtask

    initial begin
        u8 m[$];
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_empty = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_blk_valid", 512'(blk_valid), 512'(0));
        chk("rst_blk_first", 512'(blk_first), 512'(0));
        chk("rst_blk_last", 512'(blk_last), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        rdy_mode = 1;
        run_abc();

        rdy_mode = 2;
        m = {};
        send_msg(m, 1'b0, 1'b0);
        wait_drain();
        fill_msg(m, 55, 8'h41);
        send_msg(m, 1'b0, 1'b1);
        wait_drain();
        fill_msg(m, 56, 8'h41);
        send_msg(m, 1'b0, 1'b1);
        wait_drain();
        fill_msg(m, 64, 8'h00);
        first_rise = -1;
        send_msg(m, 1'b0, 1'b0);
        wait_drain();
        chk("full_blk_latency", 512'(first_rise - acc_cyc), 512'(1));

        // Backpressure: block held while the consumer is not ready.
        rdy_mode = 0;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b0);
        for (int t = 0; t < 100 && !blk_valid; t++) @(negedge clk);
        chk("bp_valid", 512'(blk_valid), 512'(1));
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_valid_held", 512'(blk_valid), 512'(1));
        end
        rdy_mode = 1;
        wait_drain();

        // Reset mid-message discards the partial data.
        for (int i = 0; i < 10; i++) send_beat(u8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 512'(in_ready), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_block", 512'(blk_valid), 512'(0));
        run_abc();

        // Randomized back-to-back messages.
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            m = {};
            for (int i = 0; i < $urandom_range(0, 150); i++) m.push_back(u8'($urandom));
            send_msg(m, ($urandom_range(0, 3) == 0), 1'b1);
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md5_block_padder.md
Name: md5_block_padder

Overview:
- Producer side of the MD5 core's block interface.
- Accepts a message as a byte stream, packs bytes into 512-bit little-endian blocks and appends MD5 padding: 0x80, zero fill, and a 64-bit little-endian bit length.
- Presents each block with first/last markers, so the core knows when to load the IV and when the message ends.
- Sits between the host/byte source and the MD5 round engine.

Parameters:
- LEN_W, 64, width of the internal bit-length counter. Zero-extended into the 64-bit length field; wraps modulo 2^LEN_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  message byte.
- in_valid  in  1  in_data/in_last/in_empty are valid.
- in_last  in  1  this beat ends the message.
- in_empty  in  1  only meaningful with in_last; the beat carries no byte (zero-length tail).
- in_ready  out  1  padder accepts a beat this cycle.
- blk_data  out  512  block; byte k at bits [8k+7:8k], word i at [32i+31:32i].
- blk_valid  out  1  blk_data/blk_first/blk_last are valid.
- blk_ready  in  1  consumer takes the block (core is idle/finished).
- blk_first  out  1  first block of the message (core loads the IV).
- blk_last  out  1  final block of the message (core asserts over).

Behaviour:
- Reset:
  - state = FILL, ptr = 0, len = 0, first_flag = 1.
  - buffer = 0, blk_valid = 0, blk_first = 0, blk_last = 0.
  - in_ready = 0 while rst is high.
  - rst mid-message discards all partial data; no block is emitted for it.
- Beat acceptance: a beat is taken when in_valid & in_ready. A beat with in_empty = 1 and in_last = 0 is illegal; its effect is undefined (verification may assert).
- Block acceptance:
  - A block is taken when blk_valid & blk_ready.
  - blk_data, blk_first and blk_last are stable and blk_valid stays high until that handshake.
- States:
  - FILL:
    - in_ready = 1.
    - Non-empty accepted beat: buffer[ptr] <= in_data; ptr <= ptr + 1; len <= len + 8.
    - ptr == 63 and not last → EMIT with kind DATA (blk_last = 0).
    - ptr == 63 and last → EMIT with kind DATA, pad_pending = 1.
    - Last with ptr < 63, or empty last beat → PAD.
  - PAD (one cycle, in_ready = 0):
    - buffer[ptr] <= 0x80; bytes ptr+1..63 are already zero.
    - If ptr ≤ 55 (ptr taken before the 0x80 write): bytes 56..63 <= length, little-endian → EMIT with kind FINAL.
    - Otherwise → EMIT with kind SPILL (blk_last = 0).
  - LEN (one cycle): buffer = 0 except bytes 56..63 = length → EMIT with kind FINAL.
  - EMIT:
    - blk_valid = 1; blk_first = first_flag; blk_last = (kind == FINAL).
    - On handshake: buffer <= 0; ptr <= 0; first_flag <= 0.
    - Next state: DATA with pad_pending → PAD (ptr = 0, 0x80 lands at byte 0); DATA otherwise → FILL; SPILL → LEN.
    - FINAL → FILL with len <= 0, first_flag <= 1, pad_pending <= 0.
- Latency:
  - Full non-last block: blk_valid rises in the cycle after the 64th byte is accepted.
  - Final block: blk_valid rises 2 cycles after the last beat is accepted (FILL → PAD → EMIT); add 2 cycles per extra block beyond the handshake.
- Mutual exclusion: in_ready and blk_valid are never high in the same cycle. Back-to-back messages are allowed; the next message's first beat is accepted in the cycle after the FINAL handshake.
- The length field is the total message bits counted across all blocks, not per block.
- blk_first and blk_last may both be 1 (single-block message).

Test Plan:
- "abc" (0x61 0x62 0x63, last on 0x63), blk_ready = 1 → one block.
  - Bytes 0..3 = 61 62 63 80; byte 56 = 0x18; all other bytes 0.
  - blk_first = blk_last = 1; blk_valid rises 2 cycles after the 0x63 accept.
- Empty message (in_last = in_empty = 1) → one block: byte 0 = 0x80, all other bytes 0, first = last = 1.
- 55 bytes of 0x41 → one block: byte 55 = 0x80, bytes 56..57 = B8 01, last = 1.
- 56 bytes of 0x41 → two blocks.
  - Block 1: byte 56 = 0x80, bytes 57..63 = 0, first = 1, last = 0.
  - Block 2: all zero except bytes 56..57 = C0 01, first = 0, last = 1.
- 64 bytes of 0x00 → two blocks.
  - Block 1: 64 zero bytes, first = 1, last = 0.
  - Block 2: byte 0 = 0x80, bytes 56..57 = 00 02, last = 1.
- Backpressure and reset:
  - Hold blk_ready = 0 for 5 cycles: blk_data stable, in_ready = 0 throughout.
  - Then assert rst after 10 bytes of a new message: no block is emitted; the next "abc" reproduces scenario 1 exactly, with blk_first = 1.
